mii_frame_scheduler: RTL
========================

# mii_frame_scheduler

Frame scheduler for the MII frame generator. It shares the single generator between `N_REQ` traffic requesters using round-robin arbitration. For each granted frame it issues a one-cycle start and drives the generator's interrupt code, then waits for frame completion with a timeout. Between frames it enforces a minimum inter-frame gap. It sits between the test-scenario sources and the generator's `i_start`/`i_interrupt` inputs.

## Interface
- `N_REQ`, 4: number of requesters, ≥2.
- `IPG_MIN`, 12: gap cycles after each frame (done or timeout), ≥1.
- `TIMEOUT_CYCLES`, 256: max cycles in WAIT_DONE before abort, ≥2.
- `CNT_W`, 16: frame counter width.
- `clk`, in, 1: clock; all logic on rising edge.
- `i_rst`, in, 1: reset, synchronous, active-high.
- `i_req`, in, `N_REQ`: per-requester frame request, level.
- `i_mode`, in, `N_REQ*8`: per-requester interrupt code; slice `k` = `[8k+7:8k]`.
- `i_frame_done`, in, 1: one-cycle pulse from generator at frame end.
- `o_grant`, out, `N_REQ`: one-hot current owner; zero when none.
- `o_start`, out, 1: one-cycle start to generator.
- `o_interrupt`, out, 8: interrupt code to generator.
- `o_busy`, out, 1: high in every state except IDLE.
- `o_timeout`, out, 1: one-cycle pulse on abort.
- `o_frame_count`, out, `CNT_W`: completed frames, wraps modulo `2^CNT_W`.

## Operation
- States: IDLE, START, WAIT_DONE, GAP.
- **IDLE**
  - If `i_req` ≠ 0, pick the round-robin winner, latch its one-hot grant and its `i_mode` slice, then go to START.
  - Otherwise stay in IDLE.
- **Round-robin arbitration**
  - Search starts at `ptr` and wraps; the first set request wins.
  - `ptr` ← winner+1 mod `N_REQ`, updated when the grant is taken.
  - Reset `ptr`=0.
- **START** (one cycle)
  - `o_start`=1.
  - Go to WAIT_DONE and clear the timer.
- **WAIT_DONE**
  - `o_interrupt` = latched mode; `o_grant` held.
  - Timer increments each cycle.
  - `i_frame_done`=1: increment the frame counter and go to GAP.
  - Otherwise, timer = `TIMEOUT_CYCLES`-1: pulse `o_timeout`, set the abort flag, go to GAP.
  - If done and timeout fall in the same cycle, done wins and there is no timeout.
- **GAP**
  - `o_grant`=0.
  - `o_interrupt` = 8'h01 (STOP_TX) if the abort flag is set, else 8'h00.
  - Stays `IPG_MIN` cycles, clears the abort flag on exit, goes to IDLE.
- `i_frame_done` is ignored outside WAIT_DONE.
- `i_req`/`i_mode` changes after grant do not affect the current frame; a dropped request still completes.
- `o_interrupt`=8'h00 in IDLE and START.

## Timing
- All outputs are registered or decoded from registered state.
- **Reset values:** `o_grant`=0, `o_start`=0, `o_interrupt`=8'h00, `o_busy`=0, `o_timeout`=0, `o_frame_count`=0, state IDLE, `ptr`=0, timer=0.
- **Request to start:** `i_req` sampled in IDLE at cycle t → `o_grant`, `o_start`, `o_busy` high at t+1; WAIT_DONE from t+2.
- **Frame completion:** done at cycle d → `o_frame_count` updated and GAP entered at d+1; GAP covers d+1…d+`IPG_MIN`; IDLE at d+`IPG_MIN`+1.
- **Back-to-back frames:** with a request pending, the next `o_start` is at d+`IPG_MIN`+2.
- **Timeout:** start at s → `o_timeout` at s+`TIMEOUT_CYCLES`+1 (exactly one cycle); GAP begins the same cycle.
- **Reset mid-frame:** next cycle all reset values apply; any in-flight grant is dropped and no count increment occurs.

## Structure
- Shared package `mii_pkg`:
  - interrupt codes `INT_NONE`=8'h00, `INT_STOP_TX`=8'h01, `INT_STOP_DATA`=8'h02;
  - scheduler state enum;
  - the generator's preamble/SFD/EOF codes.
- Sub-module `mii_rr_arbiter`:
  - combinational; inputs `req` and `ptr`; outputs one-hot `grant` and index;
  - parameter `N_REQ`.
- The scheduler holds the FSM, timer, gap counter, pointer, and frame counter.

## Test plan
- **Reset defaults:** reset, then `i_req`=4'b0000 for 20 cycles → all outputs 0, `o_busy`=0.
- **Single frame:** `i_req`=4'b0100, `i_mode[23:16]`=8'h02, done 50 cycles after start → `o_grant`=4'b0100 and `o_start` pulse one cycle after request; `o_interrupt`=8'h02 through WAIT_DONE; `o_frame_count`=1; `o_busy` low 13 cycles after done.
- **Round-robin order:** `i_req`=4'b1111 held, each frame done after 10 cycles → grant order 0,1,2,3,0; consecutive `o_start` pulses exactly 24 cycles apart (1+10+12+1).
- **Timeout:** grant with no `i_frame_done` → `o_timeout` pulse 257 cycles after `o_start`; `o_interrupt`=8'h01 for 12 GAP cycles; count unchanged.
- **Simultaneous done and timeout:** `i_frame_done` on the final timer cycle → no `o_timeout`, count increments, GAP `o_interrupt`=8'h00.
- **Reset mid-frame and counter wrap:**
  - `i_rst` during WAIT_DONE → outputs at reset values next cycle; requester 0 wins first afterward.
  - With `CNT_W`=2, 5 frames → count reads 1.

Source files
------------

// File: rtl/mii_pkg.sv
// mii_pkg
// Shared definitions for the MII frame generator and its scheduler:
// interrupt codes driven onto the generator's i_interrupt input, the
// scheduler state encoding, and the generator's framing byte codes.
// No ports (package).
package mii_pkg;

  localparam logic [7:0] INT_NONE      = 8'h00;
  localparam logic [7:0] INT_STOP_TX   = 8'h01;
  localparam logic [7:0] INT_STOP_DATA = 8'h02;

  localparam logic [7:0] CODE_PREAMBLE = 8'h55;
  localparam logic [7:0] CODE_SFD      = 8'hD5;
  localparam logic [7:0] CODE_EOF      = 8'hFD;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_GAP       = 2'd3
  } sched_state_t;

endpackage

// File: rtl/mii_rr_arbiter.sv
// mii_rr_arbiter
// Combinational round-robin arbiter. The search begins at ptr and wraps;
// the first set request wins.
// Ports:
//   req   in  N_REQ  request vector
//   ptr   in  IDX_W  search start index
//   grant out N_REQ  one-hot winner, zero when req is zero
//   idx   out IDX_W  winner index, zero when req is zero
module mii_rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx
);

  logic found;
  int   k;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      k = (int'(ptr) + i) % N_REQ;
      if (!found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/mii_frame_scheduler.sv
// mii_frame_scheduler
// Shares one MII frame generator between N_REQ requesters. Each granted
// frame gets a one-cycle start and its latched interrupt code, is watched
// by a completion timeout, and is followed by a minimum inter-frame gap.
// Ports:
//   clk           in  1        clock, rising edge
//   i_rst         in  1        synchronous active-high reset
//   i_req         in  N_REQ    per-requester level request
//   i_mode        in  N_REQ*8  per-requester interrupt code, slice k=[8k+7:8k]
//   i_frame_done  in  1        generator end-of-frame pulse
//   o_grant       out N_REQ    one-hot owner during START/WAIT_DONE
//   o_start       out 1        one-cycle start to generator
//   o_interrupt   out 8        interrupt code to generator
//   o_busy        out 1        high outside IDLE
//   o_timeout     out 1        one-cycle abort pulse
//   o_frame_count out CNT_W    completed frames, wrapping
module mii_frame_scheduler
  import mii_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int IPG_MIN        = 12,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 16
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [N_REQ*8-1:0] i_mode,
  input  logic               i_frame_done,
  output logic [N_REQ-1:0]   o_grant,
  output logic               o_start,
  output logic [7:0]         o_interrupt,
  output logic               o_busy,
  output logic               o_timeout,
  output logic [CNT_W-1:0]   o_frame_count
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam int GAP_W = $clog2(IPG_MIN + 1);

  sched_state_t     state, state_n;
  logic [N_REQ-1:0] grant_q;
  logic [7:0]       mode_q;
  logic [IDX_W-1:0] ptr;
  logic [TMR_W-1:0] timer;
  logic [GAP_W-1:0] gap_cnt;
  logic             abort;
  logic             timeout_q;
  logic [CNT_W-1:0] frame_count;

  logic [N_REQ-1:0] arb_grant;
  logic [IDX_W-1:0] arb_idx;
  logic [7:0]       mode_sel;
  logic             take_grant;
  logic             done_ok;
  logic             to_hit;

  mii_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req   (i_req),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  always_comb begin
    mode_sel = INT_NONE;
    for (int k = 0; k < N_REQ; k++) begin
      if (arb_grant[k]) mode_sel = i_mode[8*k +: 8];
    end
  end

  always_comb begin
    state_n    = state;
    take_grant = 1'b0;
    done_ok    = 1'b0;
    to_hit     = 1'b0;
    case (state)
      S_IDLE: begin
        if (|i_req) begin
          take_grant = 1'b1;
          state_n    = S_START;
        end
      end
      S_START: state_n = S_WAIT_DONE;
      S_WAIT_DONE: begin
        // done takes priority over a timeout landing in the same cycle
        if (i_frame_done) begin
          done_ok = 1'b1;
          state_n = S_GAP;
        end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          to_hit  = 1'b1;
          state_n = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      grant_q     <= '0;
      mode_q      <= INT_NONE;
      ptr         <= '0;
      timer       <= '0;
      gap_cnt     <= '0;
      abort       <= 1'b0;
      timeout_q   <= 1'b0;
      frame_count <= '0;
    end else begin
      state     <= state_n;
      timeout_q <= to_hit;

      if (take_grant) begin
        grant_q <= arb_grant;
        mode_q  <= mode_sel;
        if (int'(arb_idx) == N_REQ - 1) ptr <= '0;
        else                            ptr <= arb_idx + 1'b1;
      end

      if (state == S_START)          timer <= '0;
      else if (state == S_WAIT_DONE) timer <= timer + 1'b1;

      if (done_ok) frame_count <= frame_count + 1'b1;

      // gap counter reloads on GAP entry and counts down to zero
      if (done_ok || to_hit)                    gap_cnt <= GAP_W'(IPG_MIN - 1);
      else if (state == S_GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;

      if (to_hit)                                abort <= 1'b1;
      else if (state == S_GAP && gap_cnt == '0)  abort <= 1'b0;
    end
  end

  always_comb begin
    o_start     = (state == S_START);
    o_busy      = (state != S_IDLE);
    o_grant     = (state == S_START || state == S_WAIT_DONE) ? grant_q : '0;
    o_interrupt = INT_NONE;
    case (state)
      S_WAIT_DONE: o_interrupt = mode_q;
      S_GAP:       o_interrupt = abort ? INT_STOP_TX : INT_NONE;
      default:     o_interrupt = INT_NONE;
    endcase
  end

  assign o_timeout     = timeout_q;
  assign o_frame_count = frame_count;

endmodule
